// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and state encoding for the UART receiver.
//   DATA_W        - payload width (8 bits, LSB first on the wire)
//   CD_MAX_DEF    - default bit-period terminal count (38400 baud at 100 MHz)
//   CD_WIDTH_DEF  - default width of the bit-period counter
//   uart_state_e  - receiver FSM states
package uart_pkg;

    localparam int DATA_W       = 8;
    localparam int CD_MAX_DEF   = 2603;
    localparam int CD_WIDTH_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the asynchronous serial line.
// Both flops reset to 1 so an idle (high) line is seen during and after reset.
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   d     - asynchronous input
//   q     - synchronized output
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit sampling.
// Optional build macro: UART_RX_MAJORITY_EN - sample points use the 2-of-3
// majority of a 3-deep history of the synchronized line instead of a single
// sample.
//   clk       - system clock (rising edge)
//   rst_n     - asynchronous active-low reset
//   rx        - serial line, idle high
//   rbus      - last correctly framed byte
//   valid     - one-cycle pulse when rbus is updated
//   frame_err - one-cycle pulse when the stop bit samples low
//   busy      - high whenever the FSM is not idle
//
// state | meaning
// IDLE  | waiting for rx_s low (start edge), counter held at 0
// START | counting to the middle of the start bit to reject glitches
// DATA  | sampling 8 data bits, one per bit period, LSB first
// STOP  | sampling the stop bit; high delivers the byte, low flags an error
// BREAK | line stuck low after a framing error; wait for it to go high
module uart_rx
    import uart_pkg::*;
#(
    parameter int CD_MAX   = CD_MAX_DEF,
    parameter int CD_WIDTH = CD_WIDTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    output logic [DATA_W-1:0] rbus,
    output logic              valid,
    output logic              frame_err,
    output logic              busy
);

    localparam logic [2:0] IDLE  = ST_IDLE;
    localparam logic [2:0] START = ST_START;
    localparam logic [2:0] DATA  = ST_DATA;
    localparam logic [2:0] STOP  = ST_STOP;
    localparam logic [2:0] BREAK = ST_BREAK;

    localparam logic [CD_WIDTH-1:0] CNT_TOP  = CD_WIDTH'(CD_MAX);
    localparam logic [CD_WIDTH-1:0] CNT_HALF = CD_WIDTH'(CD_MAX / 2);
    localparam logic [CD_WIDTH-1:0] CNT_ONE  = CD_WIDTH'(1);

    logic              rx_s;
    logic              samp;
    logic [2:0]        state;
    logic [CD_WIDTH-1:0] cnt;
    logic [2:0]        idx;
    logic [DATA_W-1:0] sr;

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    logic [2:0] hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= 3'b111;
        end else begin
            hist <= {hist[1:0], rx_s};
        end
    end

    assign samp = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);
`else
    assign samp = rx_s;
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            sr        <= '0;
            rbus      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    idx <= '0;
                    if (!rx_s) begin
                        state <= START;
                    end
                end
                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt   <= '0;
                        // high at mid start bit means the low was a glitch
                        state <= samp ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                DATA: begin
                    if (cnt == CNT_TOP) begin
                        cnt <= '0;
                        sr  <= {samp, sr[DATA_W-1:1]};
                        idx <= idx + 3'd1;
                        if (idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                STOP: begin
                    if (cnt == CNT_TOP) begin
                        cnt <= '0;
                        if (samp) begin
                            rbus  <= sr;
                            valid <= 1'b1;
                            state <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                BREAK: begin
                    cnt <= '0;
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx at 16 clk per bit.
module tb_uart_rx;

    localparam int CDM  = 15;
    localparam int BIT  = CDM + 1;
    localparam int HALF = CDM / 2;
    localparam int LAT  = HALF + 9 * BIT + 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rbus;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t_low = 0;
    int n_valid = 0;
    int n_ferr = 0;
    int n_both = 0;
    logic [7:0] got_q[$];
    int         lat_q[$];
    logic [7:0] exp_rbus = 8'h00;

    uart_rx #(.CD_MAX(CDM), .CD_WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rbus      (rbus),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid) begin
            n_valid = n_valid + 1;
            got_q.push_back(rbus);
            lat_q.push_back(cyc - t_low);
        end
        if (frame_err) n_ferr = n_ferr + 1;
        if (valid && frame_err) n_both = n_both + 1;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives start, 8 data bits LSB first and the stop bit; spike inverts the
    // line for one cycle in the middle of the selected data bits. Leaves rx at
    // the stop-bit level.
    task automatic send_frame(input logic [7:0] b, input logic stop_ok, input logic [7:0] spike);
        for (int k = 0; k < 10; k++) begin
            logic v;
            v = (k == 0) ? 1'b0 : (k == 9) ? stop_ok : b[k-1];
            if (k == 0) t_low = cyc;
            for (int c = 0; c < BIT; c++) begin
                rx = (k >= 1 && k <= 8 && spike[k-1] && c == 8) ? ~v : v;
                tick(1);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx = 1'b1;
        tick(3);
        checks++; if (rbus !== 8'h00) begin errors++; $display("FAIL reset_rbus got %h want 00", rbus); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b want 0", frame_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        rst_n = 1'b1;
        tick(3);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %b want 0", busy); end
    endtask

    task automatic test_single(input logic [7:0] b, input int gap);
        int f0;
        got_q.delete();
        lat_q.delete();
        f0 = n_ferr;
        send_frame(b, 1'b1, 8'h00);
        rx = 1'b1;
        tick(gap + 2);
        exp_rbus = b;
        checks++;
        if (got_q.size() != 1) begin
            errors++; $display("FAIL single_count byte %h got %0d pulses want 1", b, got_q.size());
        end else begin
            checks++; if (got_q[0] !== b) begin errors++; $display("FAIL single_data got %h want %h", got_q[0], b); end
            checks++;
            if (lat_q[0] < LAT - 1 || lat_q[0] > LAT + 1) begin
                errors++; $display("FAIL single_latency got %0d want %0d+-1", lat_q[0], LAT);
            end
        end
        checks++; if (n_ferr != f0) begin errors++; $display("FAIL single_ferr got %0d want %0d", n_ferr, f0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy got %b want 0", busy); end
        checks++; if (rbus !== exp_rbus) begin errors++; $display("FAIL single_rbus got %h want %h", rbus, exp_rbus); end
    endtask

    task automatic test_random(input int n);
        for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            test_single(b, int'($urandom_range(0, 20)));
        end
    endtask

    task automatic test_back_to_back();
        got_q.delete();
        send_frame(8'h00, 1'b1, 8'h00);
        send_frame(8'hFF, 1'b1, 8'h00);
        rx = 1'b1;
        tick(4);
        exp_rbus = 8'hFF;
        checks++;
        if (got_q.size() != 2) begin
            errors++; $display("FAIL b2b_count got %0d want 2", got_q.size());
        end else begin
            checks++; if (got_q[0] !== 8'h00) begin errors++; $display("FAIL b2b_first got %h want 00", got_q[0]); end
            checks++; if (got_q[1] !== 8'hFF) begin errors++; $display("FAIL b2b_second got %h want ff", got_q[1]); end
        end
        checks++; if (rbus !== exp_rbus) begin errors++; $display("FAIL b2b_rbus got %h want %h", rbus, exp_rbus); end
    endtask

    task automatic test_glitch();
        int v0, f0;
        v0 = n_valid;
        f0 = n_ferr;
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_during got %b want 1", busy); end
        tick(40);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_after got %b want 0", busy); end
        checks++; if (n_valid != v0) begin errors++; $display("FAIL glitch_valid got %0d want %0d", n_valid, v0); end
        checks++; if (n_ferr != f0) begin errors++; $display("FAIL glitch_ferr got %0d want %0d", n_ferr, f0); end
    endtask

    task automatic test_frame_err();
        int v0, f0;
        v0 = n_valid;
        f0 = n_ferr;
        send_frame(8'h3C, 1'b0, 8'h00);
        tick(40);
        checks++; if (n_ferr != f0 + 1) begin errors++; $display("FAIL ferr_count got %0d want %0d", n_ferr, f0 + 1); end
        checks++; if (n_valid != v0) begin errors++; $display("FAIL ferr_valid got %0d want %0d", n_valid, v0); end
        checks++; if (rbus !== exp_rbus) begin errors++; $display("FAIL ferr_rbus got %h want %h", rbus, exp_rbus); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ferr_busy_low_line got %b want 1", busy); end
        rx = 1'b1;
        tick(4);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_busy_release got %b want 0", busy); end
        checks++; if (n_ferr != f0 + 1) begin errors++; $display("FAIL ferr_final_count got %0d want %0d", n_ferr, f0 + 1); end
    endtask

    task automatic test_reset_mid();
        int v0, f0;
        logic [7:0] b;
        b = 8'h5A;
        v0 = n_valid;
        f0 = n_ferr;
        for (int k = 0; k < 6; k++) begin
            logic v;
            v = (k == 0) ? 1'b0 : b[k-1];
            for (int c = 0; c < ((k == 5) ? 8 : BIT); c++) begin
                rx = v;
                tick(1);
            end
        end
        rst_n = 1'b0;
        rx = 1'b1;
        tick(3);
        exp_rbus = 8'h00;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
        checks++; if (rbus !== exp_rbus) begin errors++; $display("FAIL rstmid_rbus got %h want %h", rbus, exp_rbus); end
        rst_n = 1'b1;
        tick(20);
        checks++; if (n_valid != v0 || n_ferr != f0) begin
            errors++; $display("FAIL rstmid_no_pulse got valid %0d ferr %0d want %0d %0d", n_valid, n_ferr, v0, f0);
        end
        test_single(8'h81, 4);
    endtask

    task automatic test_spike();
        logic [7:0] mask;
        logic [7:0] want;
        mask = 8'($urandom_range(1, 255));
`ifdef UART_RX_MAJORITY_EN
        want = 8'hC3;
`else
        want = 8'hC3 ^ mask;
`endif
        got_q.delete();
        send_frame(8'hC3, 1'b1, mask);
        rx = 1'b1;
        tick(4);
        exp_rbus = want;
        checks++;
        if (got_q.size() != 1) begin
            errors++; $display("FAIL spike_count got %0d want 1", got_q.size());
        end
        checks++; if (rbus !== exp_rbus) begin errors++; $display("FAIL spike_rbus mask %h got %h want %h", mask, rbus, exp_rbus); end
    endtask

    initial begin
        test_reset();
        test_single(8'hA5, 4);
        test_random(6);
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid();
        test_spike();
        checks++; if (n_both != 0) begin errors++; $display("FAIL valid_ferr_overlap got %0d want 0", n_both); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CD_MAX, default 2603, clock-divider terminal count; one bit period = CD_MAX+1 clk cycles (38400 baud at 100 MHz).
REQ-002 SHALL have parameter CD_WIDTH, default 16, width of the bit-period counter; CD_MAX SHALL fit in CD_WIDTH bits.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic SHALL be on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port rx, input, 1, asynchronous serial line, idle high.
REQ-006 SHALL have port rbus, output, 8, last correctly framed byte received.
REQ-007 SHALL have port valid, output, 1, one-cycle pulse when rbus is updated.
REQ-008 SHALL have port frame_err, output, 1, one-cycle pulse when the stop bit samples low.
REQ-009 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-010 SHALL pass rx through a two-flop synchronizer; the FSM SHALL use only the synchronized value rx_s.
REQ-011 SHALL implement the states IDLE, START, DATA, STOP and BREAK, with a bit counter of CD_WIDTH bits and a 3-bit data-bit index.
REQ-012 IDLE: when rx_s==0, SHALL go to START with the counter cleared; otherwise SHALL stay in IDLE with the counter held at 0.
REQ-013 START: when the counter equals CD_MAX/2 (integer divide), SHALL sample rx_s; 1 means a glitch and SHALL return to IDLE, 0 SHALL go to DATA; the counter SHALL clear in both cases.
REQ-014 DATA: when the counter equals CD_MAX, SHALL sample rx_s into the shift register LSB-first, clear the counter and increment the index; after the 8th sample (index wraps 7->0) SHALL go to STOP.
REQ-015 STOP: when the counter equals CD_MAX, SHALL sample rx_s. 1 SHALL load rbus from the shift register, pulse valid for exactly the next cycle and go to IDLE. 0 SHALL pulse frame_err for exactly the next cycle, leave rbus unchanged and go to BREAK.
REQ-016 BREAK: SHALL remain in BREAK until rx_s==1, then go to IDLE; a line held low SHALL produce exactly one frame_err.
REQ-017 valid and frame_err SHALL never be high in the same cycle, and each SHALL be high for at most one cycle per frame.
REQ-018 rbus SHALL hold its value until the next valid frame; there is no consumer handshake, and a new byte overwrites rbus without warning.
REQ-019 At the counter increment, the counter SHALL wrap only through the explicit clear; counter arithmetic SHALL be unsigned, CD_WIDTH wide.
REQ-020 Latency: valid SHALL assert (CD_MAX/2 + 9*(CD_MAX+1) + 4) cycles after the first cycle rx is low at the pin, ±1 cycle for synchronizer phase.

Reset
REQ-021 While rst_n==0, SHALL force state=IDLE, counters=0, shift register=0, rbus=8'h00, valid=0, frame_err=0, busy=0, and set the synchronizer flops and majority history to 1.
REQ-022 Reset asserted mid-frame SHALL abort the frame with no valid or frame_err pulse; after release, reception SHALL resume only on a new falling edge of rx_s.

Configuration
REQ-023 When UART_RX_MAJORITY_EN is defined, SHALL keep a 3-deep history of rx_s and use the 2-of-3 majority of that history at every START, DATA and STOP sample point.
REQ-024 When UART_RX_MAJORITY_EN is undefined, SHALL use the single rx_s value at each sample point, and the history register SHALL not exist.

Structure
REQ-025 Package uart_pkg SHALL hold the state enum, the default CD_MAX/CD_WIDTH constants and the data width (8).
REQ-026 The two-flop synchronizer SHALL be a sub-module named uart_rx_sync (reset value 1); all other logic SHALL stay in uart_rx.

Verification (CD_MAX=15, i.e. 16 clk/bit)
REQ-027 Send 8'hA5 with a good stop bit -> one valid pulse, rbus==8'hA5, frame_err never high, busy low afterwards.
REQ-028 Send back-to-back 8'h00 then 8'hFF with no idle gap -> two valid pulses, rbus==8'h00 then 8'hFF.
REQ-029 Drive an rx low glitch of 4 cycles -> FSM returns to IDLE, no valid, no frame_err.
REQ-030 Send 8'h3C with the stop bit driven low, then hold rx low for 40 cycles -> exactly one frame_err pulse, rbus unchanged, busy stays high until rx returns high.
REQ-031 Assert rst_n low during bit 4 of 8'h5A, release, then send 8'h81 -> no pulse for the aborted frame, then valid with rbus==8'h81.
REQ-032 With UART_RX_MAJORITY_EN defined, inject a 1-cycle inverted spike at the DATA sample points of 8'hC3 -> rbus==8'hC3; without the macro the same stimulus corrupts the affected bits.
